// File: rtl/spi_receive_if.sv
// Bundle of SPI pins and consumer handshake for spi_receive.
// slave: receiver view (spi_receive); master: transmitter/consumer view.
interface spi_receive_if #(
    parameter int unsigned DATA_W = 8
);
    logic              sck;
    logic              cs;
    logic              miso;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ack;
    logic              overrun;
    logic              frame_err;
    logic              err_clr;
    logic              rx_busy;

    modport slave (
        input  sck, cs, miso, rx_ack, err_clr,
        output rx_data, rx_valid, overrun, frame_err, rx_busy
    );

    modport master (
        output sck, cs, miso, rx_ack, err_clr,
        input  rx_data, rx_valid, overrun, frame_err, rx_busy
    );
endinterface

// File: rtl/spi_receive.sv
// spi_receive: oversampling SPI byte receiver (mode with sck idle high,
// data sampled on sck rising edge, MSB first) with valid/ack output,
// sticky overrun and truncated-frame flags.
// Optional build macro SPI_RX_TIMEOUT_EN adds an sck-inactivity abort
// after TIMEOUT clk cycles while a frame is open.
module spi_receive #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 20000
) (
    input logic          clk,
    input logic          rst,
    spi_receive_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    if (DATA_W < 2 || SYNC_STAGES < 2 || TIMEOUT < 2) begin : g_bad_params
        $error("spi_receive: DATA_W, SYNC_STAGES and TIMEOUT must all be >= 2");
    end

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] miso_sync;
    logic                   sck_hist;
    logic                   cs_hist;
    logic                   sck_s;
    logic                   cs_s;
    logic                   miso_s;
    logic                   sck_rise;
    logic                   cs_fall;
    logic                   cs_rise;

    state_t                 state_q;
    state_t                 state_d;
    logic [DATA_W-1:0]      shift_q;
    logic [DATA_W-1:0]      shift_d;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic                   do_shift;
    logic                   word_done;
    logic                   frame_abort;
    logic                   overrun_set;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign miso_s   = miso_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist;
    assign cs_fall  = ~cs_s & cs_hist;
    assign cs_rise  = cs_s & ~cs_hist;

    // Synchronise the asynchronous SPI pins and keep one history bit for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_sync  <= '1;
            cs_sync   <= '1;
            miso_sync <= '0;
            sck_hist  <= 1'b1;
            cs_hist   <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
            miso_sync <= {miso_sync[SYNC_STAGES-2:0], bus.miso};
            sck_hist  <= sck_s;
            cs_hist   <= cs_s;
        end
    end

`ifdef SPI_RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT);

    logic [TO_W-1:0] to_cnt;
    logic            timeout_hit;

    assign timeout_hit = (state_q != IDLE) && !sck_rise && (to_cnt == TO_W'(TIMEOUT - 1));

    // Count clk cycles since the last sck rising edge while a frame is open.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state_q == IDLE || state_d == IDLE || sck_rise) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`endif

    // Next-state logic: the sck edge of a cycle is applied before cs_rise is judged,
    // so the abort check uses the post-shift bit count.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_d     = {shift_q[DATA_W-2:0], miso_s};
        do_shift    = 1'b0;
        word_done   = 1'b0;
        frame_abort = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    count_d = '0;
                end
            end
            SHIFT, HOLD: begin
                if (sck_rise) begin
                    do_shift = 1'b1;
                    if (count_q == CNT_W'(DATA_W - 1)) begin
                        word_done = 1'b1;
                        count_d   = '0;
                        state_d   = HOLD;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                        state_d = SHIFT;
                    end
                end
`ifdef SPI_RX_TIMEOUT_EN
                if (cs_rise || timeout_hit) begin
`else
                if (cs_rise) begin
`endif
                    state_d     = IDLE;
                    frame_abort = (count_d != '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign overrun_set = word_done && bus.rx_valid && !bus.rx_ack;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift register, bit counter, output word, handshake and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q       <= '0;
            count_q       <= '0;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.overrun   <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.rx_busy   <= 1'b0;
        end else begin
            count_q     <= count_d;
            bus.rx_busy <= (state_d != IDLE);
            if (do_shift) begin
                shift_q <= shift_d;
            end
            if (word_done) begin
                bus.rx_data  <= shift_d;
                bus.rx_valid <= 1'b1;
            end else if (bus.rx_ack) begin
                bus.rx_valid <= 1'b0;
            end
            bus.overrun   <= overrun_set | (bus.overrun & ~bus.err_clr);
            bus.frame_err <= frame_abort | (bus.frame_err & ~bus.err_clr);
        end
    end

endmodule
